// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//  Signal bundle between the PLL supervisor and its surroundings.
//  master : the sequencer. It reads pll_locked and sw_reset_req, and drives
//           pll_rst, chan_rst_n, ready, lock_timeout and lock_loss_cnt.
//  slave  : the PLL wrapper and downstream logic (the opposite directions).
interface pll_reset_sequencer_if #(
  parameter int NUM_CHAN = 4,
  parameter int CNT_W    = 8
);
  logic                pll_locked;
  logic                sw_reset_req;
  logic                pll_rst;
  logic [NUM_CHAN-1:0] chan_rst_n;
  logic                ready;
  logic                lock_timeout;
  logic [CNT_W-1:0]    lock_loss_cnt;

  modport master (
    input  pll_locked, sw_reset_req,
    output pll_rst, chan_rst_n, ready, lock_timeout, lock_loss_cnt
  );

  modport slave (
    output pll_locked, sw_reset_req,
    input  pll_rst, chan_rst_n, ready, lock_timeout, lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//  PLL supervisor that runs on the PLL reference clock. It holds the PLL in
//  reset for a fixed number of cycles, then waits for the synchronised locked
//  flag and requires it to stay high for a filter window. After that it
//  releases the channel resets one at a time at a fixed stagger. If lock does
//  not arrive within the timeout, or if lock is lost, it retries.
// Ports
//  refclk : the only clock in this block
//  rst_n  : asynchronous reset, active low
//  bus    : pll_reset_sequencer_if.master, which carries
//           pll_locked (asynchronous), sw_reset_req, pll_rst, chan_rst_n,
//           ready, lock_timeout and lock_loss_cnt
// Build option
//  PLL_RST_SEQ_LOSS_CNT_EN : when defined, lock_loss_cnt is a saturating count
//  of lock losses seen in RELEASE or RUN. When it is not defined,
//  lock_loss_cnt is tied to 0.
module pll_reset_sequencer #(
  parameter int NUM_CHAN       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 8,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STAGGER        = 4,
  parameter int CNT_W          = 8
) (
  input logic                   refclk,
  input logic                   rst_n,
  pll_reset_sequencer_if.master bus
);
  localparam int RC_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int TO_W = (LOCK_TIMEOUT > 1)   ? $clog2(LOCK_TIMEOUT)   : 1;
  localparam int FL_W = $clog2(LOCK_FILTER + 1);
  localparam int SG_W = (STAGGER > 1)        ? $clog2(STAGGER)        : 1;
  localparam int CH_W = (NUM_CHAN > 1)       ? $clog2(NUM_CHAN)       : 1;

  typedef enum logic [2:0] {
    S_RST_PLL, S_WAIT_LOCK, S_FILTER, S_RELEASE, S_RUN
  } state_t;

  state_t                r_state, w_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [RC_W-1:0]       r_rst_cnt, w_rst_cnt;
  logic [TO_W-1:0]       r_to_timer, w_to_timer;
  logic [FL_W-1:0]       r_flt, w_flt;
  logic [SG_W-1:0]       r_stg, w_stg;
  logic [CH_W-1:0]       r_ch, w_ch;
  logic [NUM_CHAN-1:0]   r_chan, w_chan;
  logic                  r_ready, w_ready;
  logic                  r_lto, w_lto;
  logic                  r_pll_rst;
  logic                  w_go_rst;
  logic                  w_locked_s;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state    = r_state;
    w_rst_cnt  = r_rst_cnt;
    w_to_timer = r_to_timer;
    w_flt      = r_flt;
    w_stg      = r_stg;
    w_ch       = r_ch;
    w_chan     = r_chan;
    w_ready    = r_ready;
    w_lto      = r_lto;
    w_go_rst   = 1'b0;
    case (r_state)
      S_RST_PLL: begin
        if (bus.sw_reset_req) begin
          w_rst_cnt = '0;
        end else if (r_rst_cnt == RC_W'(PLL_RST_CYCLES - 1)) begin
          w_state    = S_WAIT_LOCK;
          w_to_timer = '0;
        end else begin
          w_rst_cnt = r_rst_cnt + RC_W'(1);
        end
      end
      // The timeout covers WAIT_LOCK and FILTER together. A FILTER window
      // that keeps restarting because lock is glitchy still times out.
      S_WAIT_LOCK, S_FILTER: begin
        w_to_timer = r_to_timer + TO_W'(1);
        if (bus.sw_reset_req) begin
          w_go_rst = 1'b1;
        end else if (r_to_timer == TO_W'(LOCK_TIMEOUT - 1)) begin
          w_lto    = 1'b1;
          w_go_rst = 1'b1;
        end else if (r_state == S_WAIT_LOCK) begin
          if (w_locked_s) begin
            w_state = S_FILTER;
            w_flt   = '0;
          end
        end else if (!w_locked_s) begin
          w_state = S_WAIT_LOCK;
          w_flt   = '0;
        end else if (r_flt == FL_W'(LOCK_FILTER)) begin
          // Channel 0 is released on the same edge that enters RELEASE.
          w_chan[0] = 1'b1;
          w_stg     = '0;
          w_ch      = CH_W'(1);
          if (NUM_CHAN == 1) begin
            w_state = S_RUN;
            w_ready = 1'b1;
            w_lto   = 1'b0;
          end else begin
            w_state = S_RELEASE;
          end
        end else begin
          w_flt = r_flt + FL_W'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (!w_locked_s || bus.sw_reset_req) begin
          w_go_rst = 1'b1;
        end else if (r_state == S_RELEASE) begin
          if (r_stg == SG_W'(STAGGER - 1)) begin
            w_stg        = '0;
            w_chan[r_ch] = 1'b1;
            if (r_ch == CH_W'(NUM_CHAN - 1)) begin
              w_state = S_RUN;
              w_ready = 1'b1;
              w_lto   = 1'b0;
            end else begin
              w_ch = r_ch + CH_W'(1);
            end
          end else begin
            w_stg = r_stg + SG_W'(1);
          end
        end
      end
      default: w_go_rst = 1'b1;
    endcase
    if (w_go_rst) begin
      w_state   = S_RST_PLL;
      w_rst_cnt = '0;
      w_chan    = '0;
      w_ready   = 1'b0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RST_PLL;
      r_sync     <= '0;
      r_rst_cnt  <= '0;
      r_to_timer <= '0;
      r_flt      <= '0;
      r_stg      <= '0;
      r_ch       <= '0;
      r_chan     <= '0;
      r_ready    <= 1'b0;
      r_lto      <= 1'b0;
      r_pll_rst  <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.pll_locked};
      r_rst_cnt  <= w_rst_cnt;
      r_to_timer <= w_to_timer;
      r_flt      <= w_flt;
      r_stg      <= w_stg;
      r_ch       <= w_ch;
      r_chan     <= w_chan;
      r_ready    <= w_ready;
      r_lto      <= w_lto;
      r_pll_rst  <= (w_state == S_RST_PLL);
    end
  end

  assign bus.pll_rst      = r_pll_rst;
  assign bus.chan_rst_n   = r_chan;
  assign bus.ready        = r_ready;
  assign bus.lock_timeout = r_lto;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0] r_loss_cnt;
  logic             w_loss;

  // A loss counts whenever locked_s drops after the first channel release.
  // A simultaneous sw_reset_req still counts.
  assign w_loss = ((r_state == S_RELEASE) || (r_state == S_RUN)) && !w_locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)                        r_loss_cnt <= '0;
    else if (w_loss && (r_loss_cnt != '1)) r_loss_cnt <= r_loss_cnt + CNT_W'(1);
  end

  assign bus.lock_loss_cnt = r_loss_cnt;
`else
  assign bus.lock_loss_cnt = '0;
`endif
endmodule
